inst_rom_loader: RTL and testbench
==================================

Name: inst_rom_loader

Overview:
- Instruction-memory responder: the slave end of the core's fetch port, answering rom_ce/rom_addr with a 32-bit instruction in the same cycle.
- Adds a byte-serial load port, so a testbench or boot controller can fill the ROM image at run time.
- Sits beside the CPU top: fetch side connects directly to the core's rom_* ports; load side is driven by a host.

Parameters:
- ADDR_W, 10, word-index width; depth DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  fetch enable from the core (rom_ce).
- addr  input  32  fetch byte address from the core (rom_addr).
- inst  output  32  instruction returned to the core (rom_data).
- load_start  input  1  one-cycle pulse that begins a new image load.
- load_valid  input  1  load_byte is valid this cycle.
- load_byte  input  8  image byte, big-endian within each word.
- load_last  input  1  qualifies the final byte of the image; sampled with load_valid.
- load_ready  output  1  loader can accept a byte this cycle.
- busy  output  1  load in progress.
- load_words  output  ADDR_W+1  number of complete words written by the current or last load.
- load_err  output  1  sticky overflow flag: image exceeded DEPTH.

Behaviour:
- Reset: the rst edge clears state to IDLE, the byte counter, word pointer and shift register to 0, load_words to 0 and load_err to 0. While rst=1, inst=0. The memory array is not cleared; load_words=0 makes it unreachable.
- Reset during LOAD: same as above. The partial image is discarded (load_words=0), so every fetch returns 0 until a new load completes.
- State machine has two states:
  - IDLE: load_ready=0, busy=0. load_start → LOAD, and clears byte count, pointer, load_words and load_err.
  - LOAD: load_ready=1, busy=1. load_start is ignored.
- Byte accept = load_valid & load_ready.
  - Byte 0 → bits 31:24, byte 1 → 23:16, byte 2 → 15:8, byte 3 → 7:0.
  - On the edge accepting byte 3: write the word to mem[ptr], increment ptr and load_words, reset the byte count.
- load_last on an accepted byte:
  - Completes the current word, zero-padding any missing low bytes (e.g. last byte at byte-index 1 writes {b0,b1,16'h0}).
  - Writes the word, increments load_words, and returns to IDLE on that same edge.
  - load_last with load_valid=0 is ignored.
- Overflow: a byte accepted when ptr == DEPTH is dropped and load_err is set. Loading continues until load_last, which then returns to IDLE with no write.
- Fetch path is combinational from registered state (zero-latency, as the core's IF/ID latches pc and inst on the same edge):
  - idx = addr[ADDR_W+1:2]; addr[1:0] is ignored.
  - inst = 0 when any of the following hold: rst=1, ce=0, state=LOAD, addr[31:ADDR_W+2] != 0, or idx >= load_words.
  - Otherwise inst = mem[idx].
  - 0 decodes as a NOP, so the core executes NOPs while the image is absent or loading.
- Write visibility: a word written on edge N is readable from cycle N+1, once the state is IDLE.
- Load then write-then-read to the same index: the new data is returned after the load completes. There is no read-during-write hazard, because fetches during LOAD return 0.

Decomposition:
- Shared defs file holds: RstEnable, ChipEnable/ChipDisable, ZeroWord, InstBus, InstAddrBus, InstMemNumLog2 (the default for ADDR_W), and the loader state encodings LdIdle and LdLoad.
- One natural sub-module, inst_mem_array: DEPTH×32, one synchronous write port, one asynchronous read port.
- FSM, byte packer and bound checks stay in inst_rom_loader.

Test Plan:
- Reset, then ce=1, addr=0 → inst=0; load_words=0, busy=0, load_ready=0.
- Pulse load_start, then send 8 bytes 34 01 00 05 34 02 00 07 with load_last on the final byte → load_words=2, busy=0. Fetch addr 0 → 32'h34010005; addr 4 → 32'h34020007; addr 8 → 0.
- Load 5 bytes AA BB CC DD EE with load_last on EE → load_words=2; word 1 = 32'hEE000000. load_valid gaps between bytes do not change the result.
- ADDR_W=2: load 5 words, last on byte 20 → load_err=1, load_words=4, words 0-3 intact, return to IDLE.
- Assert rst in LOAD after 6 bytes → next cycle state IDLE, load_words=0, every fetch returns 0. A new load then succeeds.
- ce=0 with a valid image → inst=0. addr=32'h0000_1000 with ADDR_W=10 (out of range) → inst=0. addr=32'h3 → returns word 0.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader.
// Bus types, enables and loader state encodings.
package inst_rom_loader_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  localparam InstBus ZeroWord       = 32'h0;
  localparam int     InstMemNumLog2 = 10;

  typedef enum logic {
    LdIdle = 1'b0,
    LdLoad = 1'b1
  } ld_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port,
// one asynchronous read port.
module inst_mem_array
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = InstMemNumLog2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  InstBus            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output InstBus            rdata
);

  InstBus mem_q [2**ADDR_W];

  // Word write from the loader
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch-side instruction ROM with a byte-serial
// run-time image load port.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = InstMemNumLog2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  InstAddrBus      addr,
  output InstBus          inst,
  input  logic            load_start,
  input  logic            load_valid,
  input  logic [7:0]      load_byte,
  input  logic            load_last,
  output logic            load_ready,
  output logic            busy,
  output logic [ADDR_W:0] load_words,
  output logic            load_err
);

  localparam logic [ADDR_W:0] Depth =
    {1'b1, {ADDR_W{1'b0}}};

  ld_state_e       state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  InstBus          shreg_q, shreg_d;
  logic [ADDR_W:0] lw_q, lw_d;
  logic            err_q, err_d;

  logic            we;
  InstBus          word;
  logic            acc;
  logic            done;
  logic            ovf;
  logic [ADDR_W-1:0] idx;
  InstBus          rdata;
  logic            miss;
  logic            unused_addr;

  assign unused_addr = ^addr[1:0];

  assign load_ready = (state_q == LdLoad);
  assign busy       = (state_q == LdLoad);
  assign load_words = lw_q;
  assign load_err   = err_q;

  assign acc  = load_valid & load_ready;
  assign ovf  = (ptr_q == Depth);
  assign done = (cnt_q == 2'd3) | load_last;
  assign word = shreg_q |
    ({24'h0, load_byte} << {~cnt_q, 3'b000});

  // Next-state: FSM, byte packer and bound checks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    shreg_d = shreg_q;
    lw_d    = lw_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      LdIdle: begin
        if (load_start) begin
          state_d = LdLoad;
          cnt_d   = '0;
          ptr_d   = '0;
          shreg_d = ZeroWord;
          lw_d    = '0;
          err_d   = 1'b0;
        end
      end
      LdLoad: begin
        if (acc) begin
          if (ovf) err_d = 1'b1;
          if (done) begin
            cnt_d   = '0;
            shreg_d = ZeroWord;
            if (!ovf) begin
              we    = 1'b1;
              ptr_d = ptr_q + 1'b1;
              lw_d  = lw_q + 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = word;
          end
          if (load_last) state_d = LdIdle;
        end
      end
      default: state_d = LdIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= LdIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      shreg_q <= ZeroWord;
      lw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      shreg_q <= shreg_d;
      lw_q    <= lw_d;
      err_q   <= err_d;
    end
  end

  inst_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q[ADDR_W-1:0]),
    .wdata (word),
    .raddr (idx),
    .rdata (rdata)
  );

  assign idx  = addr[ADDR_W+1:2];
  assign miss = (rst == RstEnable)
              | (ce == ChipDisable)
              | (state_q == LdLoad)
              | (|addr[31:ADDR_W+2])
              | ({1'b0, idx} >= lw_q);

  // Zero-latency fetch; absent words read as NOP
  always_comb begin
    inst = miss ? ZeroWord : rdata;
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader at two depths
// against an image-level reference model.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;

  logic [31:0] inst_a, inst_b;
  logic        ready_a, ready_b;
  logic        busy_a, busy_b;
  logic [10:0] lw_a;
  logic [2:0]  lw_b;
  logic        err_a, err_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] img[$];
  logic [7:0] q[$];

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst_a), .load_start(load_start),
    .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready_a),
    .busy(busy_a), .load_words(lw_a),
    .load_err(err_a)
  );

  inst_rom_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr),
    .inst(inst_b), .load_start(load_start),
    .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready_b),
    .busy(busy_b), .load_words(lw_b),
    .load_err(err_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int exp_lw(input int aw);
    int w;
    int d;
    w = (img.size() + 3) / 4;
    d = 1 << aw;
    return (w < d) ? w : d;
  endfunction

  function automatic logic exp_err(input int aw);
    return img.size() > 4 * (1 << aw);
  endfunction

  function automatic logic [31:0] exp_inst(
      input int aw, input logic c,
      input logic [31:0] a);
    logic [31:0] w;
    int i;
    int n;
    if (!c) return 32'h0;
    if ((a >> (aw + 2)) != 0) return 32'h0;
    i = int'(a >> 2);
    if (i >= exp_lw(aw)) return 32'h0;
    n = img.size();
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      w = (w << 8) |
          ((4 * i + k < n) ? {24'h0, img[4 * i + k]}
                           : 32'h0);
    return w;
  endfunction

  task automatic status_checks();
    check("lw_a", {21'h0, lw_a}, exp_lw(10));
    check("lw_b", {29'h0, lw_b}, exp_lw(2));
    check("err_a", {31'h0, err_a}, {31'h0, exp_err(10)});
    check("err_b", {31'h0, err_b}, {31'h0, exp_err(2)});
    check("busy_a", {31'h0, busy_a}, 32'h0);
    check("ready_b", {31'h0, ready_b}, 32'h0);
  endtask

  task automatic fetch(input logic c,
                       input logic [31:0] a);
    @(negedge clk);
    ce = c;
    addr = a;
    #1;
    check("inst_a", inst_a, exp_inst(10, c, a));
    check("inst_b", inst_b, exp_inst(2, c, a));
  endtask

  task automatic fetch_sweep();
    fetch(1'b1, 32'h0);
    fetch(1'b1, 32'h3);
    fetch(1'b1, 32'h4);
    fetch(1'b1, 32'h8);
    fetch(1'b1, 32'hC);
    fetch(1'b1, 32'h10);
    fetch(1'b1, 32'h1000);
    fetch(1'b1, {20'h0, 12'($urandom_range(0, 63))});
    fetch(1'b1, $urandom);
    fetch(1'b0, 32'h0);
  endtask

  task automatic do_load(input logic [7:0] b[$],
                         input bit gaps,
                         input int abort_at);
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    ce = 1'b1;
    addr = 32'h0;
    #1;
    check("busy_ld", {31'h0, busy_a}, 32'h1);
    check("ready_ld", {31'h0, ready_b}, 32'h1);
    check("inst_ld", inst_a, 32'h0);
    for (int i = 0; i < b.size(); i++) begin
      if (i == abort_at) begin
        load_valid = 1'b0;
        load_last = 1'b0;
        rst = 1'b1;
        #1;
        check("inst_rst", inst_a, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        img = {};
        return;
      end
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          load_valid = 1'b0;
          load_last = 1'($urandom_range(0, 1));
          load_byte = 8'($urandom);
          @(negedge clk);
        end
      end
      load_valid = 1'b1;
      load_byte = b[i];
      load_last = (i == b.size() - 1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    img = b;
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    addr = 32'h0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_byte = 8'h0;
    load_last = 1'b0;
    img = {};
    @(negedge clk);
    @(negedge clk);
    #1;
    check("inst_in_rst", inst_a, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    status_checks();
    check("ready_a0", {31'h0, ready_a}, 32'h0);
    fetch(1'b1, 32'h0);

    q = '{8'h34, 8'h01, 8'h00, 8'h05,
          8'h34, 8'h02, 8'h00, 8'h07};
    do_load(q, 1'b0, -1);
    status_checks();
    check("w0_fixed", exp_inst(10, 1'b1, 32'h0),
          32'h34010005);
    fetch_sweep();

    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load(q, 1'b1, -1);
    status_checks();
    fetch_sweep();

    q.delete();
    for (int i = 0; i < 20; i++)
      q.push_back(8'(i + 1));
    do_load(q, 1'b0, -1);
    status_checks();
    fetch_sweep();

    q.delete();
    for (int i = 0; i < 12; i++)
      q.push_back(8'($urandom));
    do_load(q, 1'b1, 6);
    status_checks();
    fetch_sweep();
    do_load(q, 1'b0, -1);
    status_checks();
    fetch_sweep();

    for (int t = 0; t < 25; t++) begin
      q.delete();
      for (int i = 0; i < $urandom_range(1, 26); i++)
        q.push_back(8'($urandom));
      do_load(q, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0)
                ? int'($urandom_range(0, 7)) : -1);
      status_checks();
      fetch_sweep();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
